// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller between pc_control and decode
//   clk, rst                 clock; asynchronous active-low reset
//   pc_in / pc_next          current PC from pc_control, next PC back to it (combinational)
//   redirect_valid/_pc       taken branch/jump: flush and restart fetch at redirect_pc
//   mem_req_valid/ready/addr one read request per PC, at most one outstanding
//   mem_rsp_valid/data       exactly one response per accepted request
//   inst_valid/ready/data/pc instruction FIFO head toward decode
//   misalign_err             sticky misaligned-PC flag
// Optional feature: define IFETCH_MISALIGN_CHK_EN to refuse to fetch a PC with pc[1:0] != 0;
// fetch then parks until a redirect. Without it misalign_err stays 0.
module ifetch_ctrl #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign_err
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] data_q [QDEPTH];
  logic [XLEN-1:0] pcs_q [QDEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_nx;
  logic            err_q, err_d;
  logic            bad_pc, fire, push, pop;
`ifdef IFETCH_MISALIGN_CHK_EN
  assign bad_pc = |pc_in[1:0];
`else
  assign bad_pc = 1'b0;
`endif
  assign mem_req_valid = state_q == S_REQ && !bad_pc;
  assign mem_req_addr  = pc_in;
  assign fire          = mem_req_valid && mem_req_ready;
  assign inst_valid    = cnt_q != '0;
  assign inst_data     = data_q[rd_q];
  assign inst_pc       = pcs_q[rd_q];
  assign misalign_err  = err_q;
  assign pop           = inst_valid && inst_ready;
  // A response arriving with a redirect belongs to the flushed stream.
  assign push          = state_q == S_WAIT && mem_rsp_valid && !redirect_valid;
  assign pc_next       = redirect_valid ? redirect_pc : fire ? pc_in + XLEN'(4) : pc_in;
  always_comb begin
    cnt_nx   = cnt_q + CW'(push) - CW'(pop);
    cnt_d    = redirect_valid ? '0 : cnt_nx;
    rd_d     = redirect_valid ? '0 : rd_q + AW'(pop);
    wr_d     = redirect_valid ? '0 : wr_q + AW'(push);
    req_pc_d = fire ? pc_in : req_pc_q;
    err_d    = redirect_valid ? 1'b0 : (state_q == S_REQ && bad_pc) ? 1'b1 : err_q;
    state_d  = state_q;
    // Redirect: a request still in flight must have its response swallowed in S_DROP;
    // if that response lands in the redirect cycle itself there is nothing left to wait for.
    if (redirect_valid)
      state_d = (fire || ((state_q == S_WAIT || state_q == S_DROP) && !mem_rsp_valid)) ? S_DROP : S_IDLE;
    else
      case (state_q)
        S_IDLE:  state_d = (!err_q && cnt_q < FULL) ? S_REQ : S_IDLE;
        S_REQ:   state_d = fire ? S_WAIT : bad_pc ? S_IDLE : S_REQ;
        S_WAIT:  state_d = !mem_rsp_valid ? S_WAIT : (cnt_nx < FULL) ? S_REQ : S_IDLE;
        default: state_d = mem_rsp_valid ? S_IDLE : S_DROP;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) begin
        data_q[wr_q] <= mem_rsp_data;
        pcs_q[wr_q]  <= req_pc_q;
      end
    end
  end
endmodule
